// File: rtl/wasm_alu_seq.sv
// Handshaked WASM integer ALU: single-cycle ops plus an iterative restoring divider with trap reporting.
// i32 operations use the low 32 bits of each operand and return zero-extended results.
module wasm_alu_seq #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned DIV_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic            length_mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] c,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            trap,
  output logic [1:0]      trap_code,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  typedef enum logic [4:0] {
    OP_ADD = 5'b00000, OP_SUB, OP_AND, OP_OR, OP_SELECT, OP_EQZ, OP_EQ,
    OP_LT_U, OP_GT_U, OP_LE_U, OP_GE_U, OP_LT_S, OP_GT_S, OP_LE_S, OP_GE_S,
    OP_NE, OP_SHL, OP_SHR_S, OP_SHR_U, OP_ROTL, OP_ROTR, OP_MUL, OP_DIV_S,
    OP_DIV_U, OP_XOR, OP_REM_S, OP_REM_U, OP_CLZ, OP_CTZ, OP_POPCNT
  } op_t;

  localparam logic [6:0] STEPS32 = 7'(32 / DIV_STEP);
  localparam logic [6:0] STEPS64 = 7'(64 / DIV_STEP);

  state_t      state, state_nx;
  op_t         op;
  logic        is64, accept, is_div_op, is_sdiv, is_rem;
  logic [63:0] a_w, b_w, c_w, au, bu, cu, a_s, b_s;
  logic [5:0]  sh;
  logic [31:0] b32, rotl32, rotr32;
  logic [63:0] rotl64, rotr64, r, alu_res;
  logic        lt_u, gt_u, lt_s, gt_s, eq;
  logic        div_zero, div_ovf, b_min, a_ones;
  logic [63:0] a_mag, b_mag;

  logic [63:0] dq, dd, q_step, q_fin, r_fin, div_res;
  logic [64:0] dr, r_step;
  logic [6:0]  cnt;
  logic        d_is64, d_rem, d_negq, d_negr, d_trap;
  logic [1:0]  d_code;

  function automatic logic [6:0] f_clz(input logic [63:0] x, input logic w64);
    logic [6:0] n;
    n = w64 ? 7'd64 : 7'd32;
    for (int unsigned i = 0; i < 64; i++)
      if (x[i]) n = (w64 ? 7'd63 : 7'd31) - 7'(i);
    return n;
  endfunction

  function automatic logic [6:0] f_ctz(input logic [63:0] x, input logic w64);
    logic [6:0] n;
    n = w64 ? 7'd64 : 7'd32;
    for (int unsigned i = 0; i < 64; i++)
      if (x[63 - i]) n = 7'(63 - i);
    return n;
  endfunction

  function automatic logic [6:0] f_popcnt(input logic [63:0] x);
    logic [6:0] n;
    n = '0;
    for (int unsigned i = 0; i < 64; i++)
      n = n + 7'(x[i]);
    return n;
  endfunction

  assign op        = op_t'(alu_op);
  assign is64      = (XLEN == 64) && length_mode;
  assign accept    = in_valid && in_ready;
  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign busy      = (state == DIV);
  assign is_div_op = (op == OP_DIV_S) || (op == OP_DIV_U) || (op == OP_REM_S) || (op == OP_REM_U);
  assign is_sdiv   = (op == OP_DIV_S) || (op == OP_REM_S);
  assign is_rem    = (op == OP_REM_S) || (op == OP_REM_U);

  // Operands are normalised to 64 bits: zero-extended (u) and sign-extended (s) views per op width.
  assign a_w = 64'(a);
  assign b_w = 64'(b);
  assign c_w = 64'(c);
  assign au  = is64 ? a_w : {32'b0, a_w[31:0]};
  assign bu  = is64 ? b_w : {32'b0, b_w[31:0]};
  assign cu  = is64 ? c_w : {32'b0, c_w[31:0]};
  assign a_s = is64 ? a_w : {{32{a_w[31]}}, a_w[31:0]};
  assign b_s = is64 ? b_w : {{32{b_w[31]}}, b_w[31:0]};

  assign eq   = (bu == au);
  assign lt_u = (bu < au);
  assign gt_u = (au < bu);
  assign lt_s = ($signed(b_s) < $signed(a_s));
  assign gt_s = ($signed(a_s) < $signed(b_s));

  assign sh     = is64 ? a_w[5:0] : {1'b0, a_w[4:0]};
  assign b32    = bu[31:0];
  assign rotl32 = (b32 << a_w[4:0]) | (b32 >> (6'd32 - {1'b0, a_w[4:0]}));
  assign rotr32 = (b32 >> a_w[4:0]) | (b32 << (6'd32 - {1'b0, a_w[4:0]}));
  assign rotl64 = (bu << a_w[5:0]) | (bu >> (7'd64 - {1'b0, a_w[5:0]}));
  assign rotr64 = (bu >> a_w[5:0]) | (bu << (7'd64 - {1'b0, a_w[5:0]}));

  always_comb begin
    r = '0;
    case (op)
      OP_ADD:    r = bu + au;
      OP_SUB:    r = bu - au;
      OP_AND:    r = bu & au;
      OP_OR:     r = bu | au;
      OP_XOR:    r = bu ^ au;
      OP_SELECT: r = (au == '0) ? bu : cu;
      OP_EQZ:    r = 64'(au == '0);
      OP_EQ:     r = 64'(eq);
      OP_NE:     r = 64'(!eq);
      OP_LT_U:   r = 64'(lt_u);
      OP_GT_U:   r = 64'(gt_u);
      OP_LE_U:   r = 64'(!gt_u);
      OP_GE_U:   r = 64'(!lt_u);
      OP_LT_S:   r = 64'(lt_s);
      OP_GT_S:   r = 64'(gt_s);
      OP_LE_S:   r = 64'(!gt_s);
      OP_GE_S:   r = 64'(!lt_s);
      OP_SHL:    r = bu << sh;
      OP_SHR_S:  r = 64'($signed(b_s) >>> sh);
      OP_SHR_U:  r = bu >> sh;
      OP_ROTL:   r = is64 ? rotl64 : {32'b0, rotl32};
      OP_ROTR:   r = is64 ? rotr64 : {32'b0, rotr32};
      OP_MUL:    r = bu * au;
      OP_CLZ:    r = 64'(f_clz(au, is64));
      OP_CTZ:    r = 64'(f_ctz(au, is64));
      OP_POPCNT: r = 64'(f_popcnt(au));
      default:   r = '0;
    endcase
    alu_res = is64 ? r : {32'b0, r[31:0]};
  end

  assign div_zero = (au == '0);
  assign b_min    = is64 ? (b_w == {1'b1, 63'b0}) : (b_w[31:0] == 32'h8000_0000);
  assign a_ones   = is64 ? (a_w == '1) : (a_w[31:0] == '1);
  assign div_ovf  = (op == OP_DIV_S) && b_min && a_ones;
  assign a_mag    = (is_sdiv && a_s[63]) ? 64'd0 - a_s : au;
  assign b_mag    = (is_sdiv && b_s[63]) ? 64'd0 - b_s : bu;

  // Dividend is left-aligned in dq so the next quotient bit is always dq[63] for either width.
  always_comb begin
    r_step = dr;
    q_step = dq;
    for (int unsigned i = 0; i < DIV_STEP; i++) begin
      r_step = {r_step[63:0], q_step[63]};
      q_step = {q_step[62:0], 1'b0};
      if (r_step >= {1'b0, dd}) begin
        r_step    = r_step - {1'b0, dd};
        q_step[0] = 1'b1;
      end
    end
  end

  always_comb begin
    q_fin   = d_negq ? 64'd0 - dq : dq;
    r_fin   = d_negr ? 64'd0 - dr[63:0] : dr[63:0];
    div_res = d_rem ? r_fin : q_fin;
    if (!d_is64) div_res = {32'b0, div_res[31:0]};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is_div_op) state_nx = (div_zero || div_ovf) ? DONE : DIV;
      DIV:     if (cnt == 7'd1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dq     <= '0;
      dr     <= '0;
      dd     <= '0;
      cnt    <= '0;
      d_is64 <= 1'b0;
      d_rem  <= 1'b0;
      d_negq <= 1'b0;
      d_negr <= 1'b0;
      d_trap <= 1'b0;
      d_code <= '0;
    end else if (accept && is_div_op) begin
      dq     <= is64 ? b_mag : {b_mag[31:0], 32'b0};
      dr     <= '0;
      dd     <= a_mag;
      cnt    <= is64 ? STEPS64 : STEPS32;
      d_is64 <= is64;
      d_rem  <= is_rem;
      d_negq <= is_sdiv && (a_s[63] ^ b_s[63]);
      d_negr <= is_sdiv && b_s[63];
      d_trap <= div_zero || div_ovf;
      d_code <= div_zero ? 2'd1 : (div_ovf ? 2'd2 : 2'd0);
    end else if (state == DIV) begin
      dq  <= q_step;
      dr  <= r_step;
      cnt <= cnt - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      trap      <= 1'b0;
      trap_code <= '0;
    end else if (accept && !is_div_op) begin
      out_valid <= 1'b1;
      result    <= XLEN'(alu_res);
      trap      <= 1'b0;
      trap_code <= '0;
    end else if (state == DONE) begin
      out_valid <= 1'b1;
      result    <= d_trap ? '0 : XLEN'(div_res);
      trap      <= d_trap;
      trap_code <= d_code;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wasm_alu_seq.sv
// Directed bench for wasm_alu_seq (XLEN=64, DIV_STEP=1) with hand-computed expectations.
module tb_wasm_alu_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, length_mode, out_valid, out_ready, trap, busy;
  logic [4:0]  alu_op;
  logic [63:0] a, b, c, result;
  logic [1:0]  trap_code;
  int          n_checks = 0;
  int          n_pass = 0;
  int          lat;
  int          seen;

  always #5 clk = ~clk;

  wasm_alu_seq #(.XLEN(64), .DIV_STEP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .length_mode(length_mode), .a(a), .b(b), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .trap(trap), .trap_code(trap_code), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input logic [4:0] op, input logic m, input logic [63:0] av,
                       input logic [63:0] bv, input logic [63:0] cv);
    alu_op = op; length_mode = m; a = av; b = bv; c = cv; in_valid = 1'b1;
    check("in_ready at issue", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    lat = 1;
    while (!out_valid && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  task automatic single(input string tag, input logic [4:0] op, input logic m,
                        input logic [63:0] av, input logic [63:0] bv, input logic [63:0] exp);
    issue(op, m, av, bv, 64'd0);
    check({tag, " valid"}, 64'(out_valid), 64'd1);
    check(tag, result, exp);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; length_mode = 1'b0;
    alu_op = '0; a = '0; b = '0; c = '0;
    repeat (3) tick();
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst result", result, 64'd0);
    check("rst trap", 64'(trap), 64'd0);
    check("rst trap_code", 64'(trap_code), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    rst = 1'b0;
    check("in_ready after rst", 64'(in_ready), 64'd1);

    // back-to-back single-cycle ops
    issue(5'b00000, 1'b0, 64'd1, 64'hFFFF_FFFF, 64'd0);
    check("b2b add valid", 64'(out_valid), 64'd1);
    check("b2b add i32", result, 64'd0);
    issue(5'b00001, 1'b1, 64'd7, 64'd5, 64'd0);
    check("b2b sub valid", 64'(out_valid), 64'd1);
    check("b2b sub i64", result, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    check("b2b drained", 64'(out_valid), 64'd0);

    // divider, normal path
    issue(5'b10110, 1'b0, 64'd2, 64'hDEAD_BEEF_FFFF_FFF9, 64'd0);
    check("div busy", 64'(busy), 64'd1);
    wait_out();
    check("div_s latency", 64'(lat), 64'd34);
    check("div_s i32", result, 64'h0000_0000_FFFF_FFFD);
    check("div_s trap", 64'(trap), 64'd0);
    issue(5'b11001, 1'b0, 64'd2, 64'hFFFF_FFF9, 64'd0);
    wait_out();
    check("rem_s latency", 64'(lat), 64'd34);
    check("rem_s i32", result, 64'h0000_0000_FFFF_FFFF);
    issue(5'b10111, 1'b1, 64'd3, 64'd1000, 64'd0);
    wait_out();
    check("div_u i64 latency", 64'(lat), 64'd66);
    check("div_u i64", result, 64'd333);
    issue(5'b11010, 1'b1, 64'd3, 64'd1000, 64'd0);
    wait_out();
    check("rem_u i64", result, 64'd1);

    // traps
    issue(5'b10111, 1'b1, 64'd0, 64'd123, 64'd0);
    wait_out();
    check("dz latency", 64'(lat), 64'd2);
    check("dz trap", 64'(trap), 64'd1);
    check("dz code", 64'(trap_code), 64'd1);
    check("dz result", result, 64'd0);
    issue(5'b10110, 1'b0, 64'hFFFF_FFFF, 64'h8000_0000, 64'd0);
    wait_out();
    check("ovf latency", 64'(lat), 64'd2);
    check("ovf trap", 64'(trap), 64'd1);
    check("ovf code", 64'(trap_code), 64'd2);
    issue(5'b11001, 1'b0, 64'hFFFF_FFFF, 64'h8000_0000, 64'd0);
    wait_out();
    check("rem_s min latency", 64'(lat), 64'd34);
    check("rem_s min result", result, 64'd0);
    check("rem_s min trap", 64'(trap), 64'd0);
    check("rem_s min code", 64'(trap_code), 64'd0);
    tick();

    // backpressure
    out_ready = 1'b0;
    issue(5'b00010, 1'b1, 64'hFF0F, 64'h1234, 64'd0);
    alu_op = 5'b00011; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp valid", 64'(out_valid), 64'd1);
      check("bp result held", result, 64'h1204);
      check("bp in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp next valid", 64'(out_valid), 64'd1);
    check("bp next or", result, 64'hFF3F);
    tick();
    check("bp drained", 64'(out_valid), 64'd0);

    // bit ops, compares, shifts, rotates
    single("rotl i32", 5'b10011, 1'b0, 64'd33, 64'hFFFF_FFFF_8000_0001, 64'h3);
    single("rotr i64 0", 5'b10100, 1'b1, 64'd64, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    single("clz i64 0", 5'b11011, 1'b1, 64'd0, 64'd0, 64'd64);
    single("clz i32 1", 5'b11011, 1'b0, 64'hFFFF_0000_0000_0001, 64'd0, 64'd31);
    single("ctz i32", 5'b11100, 1'b0, 64'h100, 64'd0, 64'd8);
    single("ctz i32 0", 5'b11100, 1'b0, 64'hFFFF_0000_0000_0000, 64'd0, 64'd32);
    single("popcnt i64", 5'b11101, 1'b1, 64'hF0F0, 64'd0, 64'd8);
    single("lt_s i32", 5'b01011, 1'b0, 64'd1, 64'hFFFF_FFFF, 64'd1);
    single("lt_u i32", 5'b00111, 1'b0, 64'd1, 64'hFFFF_FFFF, 64'd0);
    single("gt_s i64", 5'b01100, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'd1);
    single("shr_s i32", 5'b10001, 1'b0, 64'd4, 64'h8000_0000, 64'hF800_0000);
    single("mul i32", 5'b10101, 1'b0, 64'h10001, 64'h10001, 64'h0002_0001);
    single("eqz i32", 5'b00101, 1'b0, 64'hAB00_0000_0000_0000, 64'd0, 64'd1);
    single("reserved", 5'b11110, 1'b1, 64'd9, 64'd9, 64'd0);
    issue(5'b00100, 1'b1, 64'd0, 64'd11, 64'd22);
    check("select a=0", result, 64'd11);
    issue(5'b00100, 1'b1, 64'd5, 64'd11, 64'd22);
    check("select a!=0", result, 64'd22);

    // reset during a divide
    issue(5'b10111, 1'b1, 64'd3, 64'd1000, 64'd0);
    repeat (10) tick();
    check("mid-div busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("no output after abort", 64'(seen), 64'd0);
    single("add after abort", 5'b00000, 1'b1, 64'd3, 64'd2, 64'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
